// File: rtl/div_ctrl_pkg.sv
// Shared constants for the multi-cycle signed divider: widths, state encoding
// and latency figures used by the controller and its environment.
package div_ctrl_pkg;

   localparam int unsigned DIV_WIDTH   = 32;
   localparam int unsigned DIV_CNT_W   = 5;
   localparam int unsigned DIV_ITER    = 32;
   localparam int unsigned DIV_LATENCY = 34;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_CALC = 2'd1;
   localparam state_t S_FIX  = 2'd2;

   // The unused encoding 2'd3 behaves exactly like IDLE.
   function automatic state_t decode_state(input state_t s);
      return (s == 2'd3) ? S_IDLE : s;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Start/ready handshake between the execute-stage stall logic (master)
// and the divider controller (slave).
interface div_ctrl_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_DIV,
      output data_operandA,
      output data_operandB,
      input  data_result,
      input  data_exception,
      input  data_resultRDY,
      input  busy
   );

   modport slave (
      input  ctrl_DIV,
      input  data_operandA,
      input  data_operandB,
      output data_result,
      output data_exception,
      output data_resultRDY,
      output busy
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor using the 32-bit subtractor plus an explicit 33rd borrow bit.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_c_o,
   output logic [WIDTH-1:0] quo_c_o,
   output logic             borrow_c_o
);

   logic [WIDTH:0] shift_c;
   logic [WIDTH:0] sub_c;

   // A set shift_c[WIDTH] means R' >= 2^WIDTH > D, so the 32-bit borrow is cancelled.
   always_comb begin
      shift_c    = {rem_i, quo_i[WIDTH-1]};
      sub_c      = {1'b0, shift_c[WIDTH-1:0]} - {1'b0, div_i};
      borrow_c_o = sub_c[WIDTH] & ~shift_c[WIDTH];
      rem_c_o    = borrow_c_o ? shift_c[WIDTH-1:0] : sub_c[WIDTH-1:0];
      quo_c_o    = {quo_i[WIDTH-2:0], ~borrow_c_o};
   end

endmodule

// File: rtl/div_ctrl.sv
// Signed 32-bit restoring divider controller: sequences 32 iterations of
// div_step, applies the result sign, and reports via a start/ready handshake.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = DIV_CNT_W
) (
   input  logic        clock,
   input  logic        reset,
   div_ctrl_if.slave   bus
);

   state_t           state_q, state_d, st_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             sign_q, sign_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic [WIDTH-1:0] neg_in_c, neg_c, neg_b_c;
   logic [WIDTH-1:0] step_r_c, step_q_c;
   logic             unused_borrow_c;
   logic             start_c, div_zero_c;

   assign st_c       = decode_state(state_q);
   assign start_c    = bus.ctrl_DIV;
   assign div_zero_c = (bus.data_operandB == '0);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i      (r_q),
      .quo_i      (q_q),
      .div_i      (d_q),
      .rem_c_o    (step_r_c),
      .quo_c_o    (step_q_c),
      .borrow_c_o (unused_borrow_c)
   );

   // Shared negator: |A| while idle, final sign fix of Q in FIX.
   always_comb begin
      neg_in_c = bus.data_operandA;
      if (st_c == S_FIX) begin
         neg_in_c = q_q;
      end
      neg_c   = WIDTH'(0) - neg_in_c;
      neg_b_c = WIDTH'(0) - bus.data_operandB;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = st_c;
      case (st_c)
         S_IDLE: begin
            if (start_c && !div_zero_c) begin
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      r_d    = r_q;
      q_d    = q_q;
      d_d    = d_q;
      sign_d = sign_q;
      res_d  = res_q;
      exc_d  = exc_q;
      rdy_d  = 1'b0;
      case (st_c)
         S_IDLE: begin
            if (start_c) begin
               if (div_zero_c) begin
                  res_d = '0;
                  exc_d = 1'b1;
                  rdy_d = 1'b1;
               end else begin
                  sign_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                  q_d    = bus.data_operandA[WIDTH-1] ? neg_c : bus.data_operandA;
                  d_d    = bus.data_operandB[WIDTH-1] ? neg_b_c : bus.data_operandB;
                  r_d    = '0;
                  cnt_d  = '0;
               end
            end
         end
         S_CALC: begin
            r_d   = step_r_c;
            q_d   = step_q_c;
            cnt_d = cnt_q + CNT_W'(1);
         end
         S_FIX: begin
            res_d = sign_q ? neg_c : q_q;
            exc_d = 1'b0;
            rdy_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         r_q    <= '0;
         q_q    <= '0;
         d_q    <= '0;
         sign_q <= 1'b0;
         res_q  <= '0;
         exc_q  <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         r_q    <= r_d;
         q_q    <= q_d;
         d_q    <= d_d;
         sign_q <= sign_d;
         res_q  <= res_d;
         exc_q  <= exc_d;
         rdy_q  <= rdy_d;
      end
   end

   assign bus.data_result    = res_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = (st_c != S_IDLE);

endmodule
